addr_gen_stream: RTL
====================

Name: addr_gen_stream

Overview:
- Parametrised, handshaked successor to the vector register-group address generator.
- Accepts one register-group request and emits one (register address, element offset) beat per cycle under out_ready backpressure.
- Supports integer LMUL 1..2^REG_WIDTH and fractional LMUL 1/2, 1/4, 1/8.
- Accepts back-to-back requests with no bubble, and supports a synchronous flush.
- Sits between the vector decode/issue stage and the vector register file read/write ports.

Parameters:
ADDR_WIDTH, 5, vector register address width (2^ADDR_WIDTH registers)
OFF_WIDTH, 8, element-offset width within one register
REG_WIDTH, 3, register-index width within a group (max group = 2^REG_WIDTH registers)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of the current group; pending request dropped
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_addr  input  ADDR_WIDTH  base register of the group
req_max_reg  input  REG_WIDTH  last register index (integer LMUL - 1)
req_max_off  input  OFF_WIDTH  last offset within a full register
req_frac  input  2  0 = integer LMUL; 1/2/3 = LMUL 1/2, 1/4, 1/8
out_valid  output  1  beat valid
out_ready  input  1  consumer accepts the beat
addr_out  output  ADDR_WIDTH  register address = base + reg index, modulo 2^ADDR_WIDTH
off_out  output  OFF_WIDTH  element offset
addr_start  output  1  current beat is the first of its group
addr_end  output  1  current beat is the last of its group
idle  output  1  no group in flight, no beat valid

Behaviour:
- States: IDLE, BUSY. All beat outputs are registered.
- Reset (rst_n low, asynchronous): state=IDLE; out_valid, addr_out, off_out, addr_start, addr_end = 0; idle=1; internal counters = 0.
- req_ready = (state==IDLE) | (out_valid & out_ready & addr_end), and is forced 0 while flush=1.

Request latch (on accept):
- Capture base = req_addr.
- If req_frac==0: eff_max_reg = req_max_reg and eff_max_off = req_max_off.
- Otherwise: eff_max_reg = 0 and eff_max_off = ((req_max_off+1) >> req_frac) - 1.
  - The sum is computed in OFF_WIDTH+1 bits.
  - A zero quotient clamps eff_max_off to 0 (one beat).
- Latency: the first beat is presented the cycle after accept, with out_valid=1, reg=0, off=0, addr_start=1.

Beat sequence:
- Offset is the inner loop: off runs 0..eff_max_off; then reg increments and off returns to 0, until reg==eff_max_reg and off==eff_max_off.
- Total beats = (eff_max_reg+1)*(eff_max_off+1).
- A beat advances only when out_valid & out_ready.
- While out_ready=0, all beat outputs hold stable; out_valid stays 1.
- addr_end=1 exactly when reg==eff_max_reg and off==eff_max_off. A single-beat group has addr_start=addr_end=1.

Group completion:
- When the last beat is consumed with no new accept: next cycle state=IDLE, out_valid=0, idle=1.
- Back-to-back: if the last beat is consumed and a new request is accepted in the same cycle, the new group's first beat appears the next cycle with no bubble.

Flush:
- Takes priority over beat advance and over request accept.
- Next cycle: state=IDLE, out_valid=0, addr_start=addr_end=0, idle=1. addr_out and off_out hold their last value.

Other rules:
- Address wrap: addr_out = (base + reg) mod 2^ADDR_WIDTH; no error flag.
- idle = (state==IDLE) & ~out_valid.

Test Plan:
- Reset, then req addr=4, max_reg=1, max_off=2, frac=0, out_ready=1 → 6 beats: (4,0)(4,1)(4,2)(5,0)(5,1)(5,2); addr_start on beat 1 only; addr_end on beat 6; idle=1 the cycle after.
- Same request with out_ready toggling 1,0,0,1... → outputs frozen during stalls; same 6-beat sequence; no beat duplicated or skipped.
- frac=2, max_off=15, max_reg=3 → 4 beats, addr 7 (base 7), off 0..3; frac=3, max_off=3 → 1 beat with addr_start=addr_end=1.
- Back-to-back: req A (addr 2, 2 beats) then req B (addr 9, max_reg=0, max_off=0) held valid → B accepted on A's last handshake; beats 2/0, 2/1, 9/0 on consecutive cycles.
- Wrap: addr=30, max_reg=3, max_off=0 → addr_out 30, 31, 0, 1.
- Flush on the third beat of an 8-beat group, with req_valid high in the same cycle → out_valid=0 and idle=1 next cycle; request not accepted until the following cycle. Separately, asserting rst_n=0 mid-group clears all outputs immediately without waiting for a clock edge.

Source files
------------

// File: rtl/addr_gen_stream.sv
// Streaming vector register-group address generator: one (register, offset)
// beat per handshake, offset as the inner loop, with flush and back-to-back requests.
module addr_gen_stream #(
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8,
  parameter int REG_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]  req_max_reg,
  input  logic [OFF_WIDTH-1:0]  req_max_off,
  input  logic [1:0]            req_frac,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [OFF_WIDTH-1:0]  off_out,
  output logic                  addr_start,
  output logic                  addr_end,
  output logic                  idle
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  base;
  logic [REG_WIDTH-1:0]   max_reg;
  logic [OFF_WIDTH-1:0]   max_off;
  logic [REG_WIDTH-1:0]   reg_idx;

  // Fractional LMUL shrinks the group to a slice of one register; a slice
  // smaller than one element still produces a single beat.
  function automatic logic [OFF_WIDTH-1:0] frac_max_off(
    input logic [OFF_WIDTH-1:0] mo,
    input logic [1:0]           frac
  );
    logic [OFF_WIDTH:0] quot;
    quot = ({1'b0, mo} + (OFF_WIDTH+1)'(1)) >> frac;
    if (frac == 2'd0)
      return mo;
    else if (quot == '0)
      return '0;
    else
      return OFF_WIDTH'(quot - (OFF_WIDTH+1)'(1));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(
    input logic [ADDR_WIDTH-1:0] b,
    input logic [REG_WIDTH-1:0]  r
  );
    return ADDR_WIDTH'({{REG_WIDTH{1'b0}}, b} + {{ADDR_WIDTH{1'b0}}, r});
  endfunction

  logic                  advance;
  logic                  accept;
  logic                  off_wrap;
  logic [REG_WIDTH-1:0]  nxt_reg;
  logic [OFF_WIDTH-1:0]  nxt_off;
  logic [REG_WIDTH-1:0]  acc_max_reg;
  logic [OFF_WIDTH-1:0]  acc_max_off;

  assign advance     = out_valid & out_ready;
  assign req_ready   = ~flush & ((state == IDLE) | (advance & addr_end));
  assign accept      = req_valid & req_ready;
  assign off_wrap    = (off_out == max_off);
  assign nxt_reg     = off_wrap ? reg_idx + REG_WIDTH'(1) : reg_idx;
  assign nxt_off     = off_wrap ? '0 : off_out + OFF_WIDTH'(1);
  assign acc_max_reg = (req_frac == 2'd0) ? req_max_reg : '0;
  assign acc_max_off = frac_max_off(req_max_off, req_frac);
  assign idle        = (state == IDLE) & ~out_valid;

  // Beat register stage: flush beats accept, accept beats plain advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      max_reg    <= '0;
      max_off    <= '0;
      reg_idx    <= '0;
      out_valid  <= 1'b0;
      addr_out   <= '0;
      off_out    <= '0;
      addr_start <= 1'b0;
      addr_end   <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      addr_start <= 1'b0;
      addr_end   <= 1'b0;
    end else if (accept) begin
      state      <= BUSY;
      base       <= req_addr;
      max_reg    <= acc_max_reg;
      max_off    <= acc_max_off;
      reg_idx    <= '0;
      out_valid  <= 1'b1;
      addr_out   <= req_addr;
      off_out    <= '0;
      addr_start <= 1'b1;
      addr_end   <= (acc_max_reg == '0) && (acc_max_off == '0);
    end else if (advance) begin
      if (addr_end) begin
        state      <= IDLE;
        out_valid  <= 1'b0;
        addr_start <= 1'b0;
        addr_end   <= 1'b0;
      end else begin
        reg_idx    <= nxt_reg;
        off_out    <= nxt_off;
        addr_out   <= wrap_addr(base, nxt_reg);
        addr_start <= 1'b0;
        addr_end   <= (nxt_reg == max_reg) && (nxt_off == max_off);
      end
    end
  end

endmodule
